// File: rtl/mode4_exp_sum_acc_pkg.sv
// mode4_exp_sum_acc_pkg: shared FP16 format constants, FSM states and the FP adder
package mode4_exp_sum_acc_pkg;

    localparam int DATAWIDTH = 16;
    localparam int MANTISSA  = 10;
    localparam int EXPONENT  = 5;
    localparam logic [DATAWIDTH-1:0] FP_ZERO = '0;
    // working significand: hidden bit + mantissa + guard/round/sticky
    localparam int WW   = MANTISSA + 4;
    localparam int EMAX = (1 << EXPONENT) - 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    // round-to-nearest-even FP add; want_st selects the DW-style status byte
    // (bit0 zero, bit1 infinity, bit2 invalid, bit3 tiny, bit4 huge, bit5 inexact)
    function automatic logic [DATAWIDTH-1:0] fp_core(
        input logic [DATAWIDTH-1:0] a,
        input logic [DATAWIDTH-1:0] b,
        input logic                 want_st
    );
        logic [DATAWIDTH-1:0] x, y, res;
        logic [7:0]           st;
        logic [MANTISSA:0]    mx, my;
        logic [2*WW-1:0]      ysh;
        logic [WW-1:0]        ya;
        logic [WW:0]          s;
        logic [MANTISSA+1:0]  m;
        logic                 xnan, ynan, xinf, yinf, rs;
        int                   ex, ey;
        // larger magnitude first so the result sign is x's sign
        {x, y} = (b[DATAWIDTH-2:0] > a[DATAWIDTH-2:0]) ? {b, a} : {a, b};
        xinf = (&x[MANTISSA +: EXPONENT]) && ~|x[MANTISSA-1:0];
        yinf = (&y[MANTISSA +: EXPONENT]) && ~|y[MANTISSA-1:0];
        xnan = (&x[MANTISSA +: EXPONENT]) && |x[MANTISSA-1:0];
        ynan = (&y[MANTISSA +: EXPONENT]) && |y[MANTISSA-1:0];
        ex = (x[MANTISSA +: EXPONENT] == '0) ? 1 : int'(x[MANTISSA +: EXPONENT]);
        ey = (y[MANTISSA +: EXPONENT] == '0) ? 1 : int'(y[MANTISSA +: EXPONENT]);
        mx = {|x[MANTISSA +: EXPONENT], x[MANTISSA-1:0]};
        my = {|y[MANTISSA +: EXPONENT], y[MANTISSA-1:0]};
        // align the smaller operand, folding shifted-out bits into sticky
        ysh = {my, 3'b000, {WW{1'b0}}} >> (ex - ey);
        ya  = {ysh[2*WW-1:WW+1], ysh[WW] | (|ysh[WW-1:0])};
        s   = (x[DATAWIDTH-1] == y[DATAWIDTH-1]) ? {1'b0, mx, 3'b000} + {1'b0, ya}
                                                 : {1'b0, mx, 3'b000} - {1'b0, ya};
        if (s[WW]) begin
            s  = {1'b0, s[WW:2], s[1] | s[0]};
            ex = ex + 1;
        end
        // normalise left, stopping at the subnormal exponent
        for (int i = 0; i < WW; i++) begin
            if (!s[WW-1] && ex > 1) begin
                s  = s << 1;
                ex = ex - 1;
            end
        end
        rs = s[1] | s[0];
        m  = {1'b0, s[WW-1:3]} + {{(MANTISSA+1){1'b0}}, s[2] & (rs | s[3])};
        if (m[MANTISSA+1]) begin
            m  = m >> 1;
            ex = ex + 1;
        end
        st  = '0;
        res = '0;
        if (xnan || ynan || (xinf && yinf && (x[DATAWIDTH-1] != y[DATAWIDTH-1]))) begin
            res   = {1'b0, {EXPONENT{1'b1}}, 1'b1, {(MANTISSA-1){1'b0}}};
            st[2] = 1'b1;
        end else if (xinf) begin
            res   = x;
            st[1] = 1'b1;
        end else if (s == '0) begin
            res   = {x[DATAWIDTH-1] & y[DATAWIDTH-1], {(DATAWIDTH-1){1'b0}}};
            st[0] = 1'b1;
        end else if (ex >= EMAX) begin
            res   = {x[DATAWIDTH-1], {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
            st[1] = 1'b1;
            st[4] = 1'b1;
            st[5] = 1'b1;
        end else begin
            res   = {x[DATAWIDTH-1], m[MANTISSA] ? EXPONENT'(ex) : {EXPONENT{1'b0}}, m[MANTISSA-1:0]};
            st[3] = !m[MANTISSA];
            st[5] = s[2] | rs;
        end
        return want_st ? {{(DATAWIDTH-8){1'b0}}, st} : res;
    endfunction

    function automatic logic [DATAWIDTH-1:0] fp_add(
        input logic [DATAWIDTH-1:0] a,
        input logic [DATAWIDTH-1:0] b
    );
        return fp_core(a, b, 1'b0);
    endfunction

    function automatic logic [7:0] fp_stat(
        input logic [DATAWIDTH-1:0] a,
        input logic [DATAWIDTH-1:0] b
    );
        return 8'(fp_core(a, b, 1'b1));
    endfunction

endpackage

// File: rtl/mode4_exp_sum_acc_tree8.sv
// exp_sum_tree8: registered 3-level FP16 adder tree over 8 lanes; SUM_STATUS_EN adds per-cycle adder status
module exp_sum_tree8
    import mode4_exp_sum_acc_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_in,
    input  logic                       last_in,
    input  logic [7:0][DATAWIDTH-1:0]  lanes,
`ifdef SUM_STATUS_EN
    output logic [7:0]                 status,
`endif
    output logic [DATAWIDTH-1:0]       sum,
    output logic                       sum_valid,
    output logic                       sum_last
);

    logic [7:0][DATAWIDTH-1:0] s0;
    logic [3:0][DATAWIDTH-1:0] s1, a1;
    logic [1:0][DATAWIDTH-1:0] s2, a2;
    logic [DATAWIDTH-1:0]      a3;
    logic [3:0]                vld, lst;

    // adders between capture -> L1 -> L2 -> L3
    always_comb begin
        for (int i = 0; i < 4; i++) a1[i] = fp_add(s0[2*i], s0[2*i+1]);
        for (int i = 0; i < 2; i++) a2[i] = fp_add(s1[2*i], s1[2*i+1]);
        a3 = fp_add(s2[0], s2[1]);
    end

    // tree never stalls; valid/last ride alongside the data
    always_ff @(posedge clk) begin
        vld <= reset ? {vld[2:0], valid_in} : 4'b0000;
        lst <= reset ? {lst[2:0], valid_in & last_in} : 4'b0000;
        s0  <= valid_in ? lanes : s0;
        s1  <= a1;
        s2  <= a2;
        sum <= a3;
    end

    assign sum_valid = vld[3];
    assign sum_last  = lst[3];

`ifdef SUM_STATUS_EN
    // status of every adder whose operands are valid this cycle
    always_comb begin
        status = 8'h00;
        for (int i = 0; i < 4; i++) status = status | (vld[0] ? fp_stat(s0[2*i], s0[2*i+1]) : 8'h00);
        for (int i = 0; i < 2; i++) status = status | (vld[1] ? fp_stat(s1[2*i], s1[2*i+1]) : 8'h00);
        status = status | (vld[2] ? fp_stat(s2[0], s2[1]) : 8'h00);
    end
`endif

endmodule

// File: rtl/mode4_exp_sum_acc.sv
// mode4_exp_sum_acc: per-vector FP16 sum of 8-lane exp() beats (softmax divisor); SUM_STATUS_EN enables sticky adder status
module mode4_exp_sum_acc
    import mode4_exp_sum_acc_pkg::*;
#(
    parameter int BEAT_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic                  last_in,
    input  logic [DATAWIDTH-1:0]  inp0,
    input  logic [DATAWIDTH-1:0]  inp1,
    input  logic [DATAWIDTH-1:0]  inp2,
    input  logic [DATAWIDTH-1:0]  inp3,
    input  logic [DATAWIDTH-1:0]  inp4,
    input  logic [DATAWIDTH-1:0]  inp5,
    input  logic [DATAWIDTH-1:0]  inp6,
    input  logic [DATAWIDTH-1:0]  inp7,
    output logic                  in_ready,
    output logic [DATAWIDTH-1:0]  outp,
    output logic                  outp_valid,
    output logic [BEAT_CNT_W-1:0] beat_count,
    output logic                  busy,
    output logic [7:0]            status
);

    state_t               state;
    logic                 accept, tvalid, tlast, have_acc;
    logic [DATAWIDTH-1:0] tsum, acc, nsum;
`ifdef SUM_STATUS_EN
    logic [7:0]           tstat;
`endif

    assign in_ready = state != DRAIN;
    assign busy     = state != IDLE;
    assign accept   = valid_in && in_ready;
    assign nsum     = have_acc ? fp_add(acc, tsum) : tsum;

    exp_sum_tree8 u_tree (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (accept),
        .last_in   (last_in),
        .lanes     ({inp7, inp6, inp5, inp4, inp3, inp2, inp1, inp0}),
`ifdef SUM_STATUS_EN
        .status    (tstat),
`endif
        .sum       (tsum),
        .sum_valid (tvalid),
        .sum_last  (tlast)
    );

    // accumulate L3 sums; the last one publishes the vector total and rearms
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc        <= FP_ZERO;
            have_acc   <= 1'b0;
            outp       <= FP_ZERO;
            outp_valid <= 1'b0;
        end else begin
            outp_valid <= tvalid && tlast;
            if (tvalid && tlast) begin
                outp     <= nsum;
                acc      <= FP_ZERO;
                have_acc <= 1'b0;
            end else if (tvalid) begin
                acc      <= nsum;
                have_acc <= 1'b1;
            end
        end
    end

    // vector framing: count beats, block input while the tree drains
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            beat_count <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state      <= last_in ? DRAIN : ACCUM;
                    beat_count <= BEAT_CNT_W'(1);
                end
                ACCUM: if (accept) begin
                    state      <= last_in ? DRAIN : ACCUM;
                    beat_count <= (&beat_count) ? beat_count : beat_count + 1'b1;
                end
                DRAIN: if (tvalid && tlast) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SUM_STATUS_EN
    // sticky status, restarted by the first beat of each vector
    always_ff @(posedge clk) begin
        status <= (!reset || (accept && state == IDLE)) ? 8'h00
                : status | tstat | ((tvalid && have_acc) ? fp_stat(acc, tsum) : 8'h00);
    end
`else
    assign status = 8'h00;
`endif

endmodule

// File: tb/tb_mode4_exp_sum_acc.sv
// tb_mode4_exp_sum_acc: directed and randomized checks of the per-vector FP16 exp sum
module tb_mode4_exp_sum_acc;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0;
    logic        last_in = 1'b0;
    logic [15:0] lane [8];
    logic        in_ready, outp_valid, busy;
    logic [15:0] outp;
    logic [7:0]  beat_count, status;
    int          total = 0;
    int          bad = 0;

    logic [15:0] tbl [6] = '{16'h0000, 16'h3400, 16'h3800, 16'h3C00, 16'h4000, 16'h4200};

    mode4_exp_sum_acc dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .last_in    (last_in),
        .inp0       (lane[0]),
        .inp1       (lane[1]),
        .inp2       (lane[2]),
        .inp3       (lane[3]),
        .inp4       (lane[4]),
        .inp5       (lane[5]),
        .inp6       (lane[6]),
        .inp7       (lane[7]),
        .in_ready   (in_ready),
        .outp       (outp),
        .outp_valid (outp_valid),
        .beat_count (beat_count),
        .busy       (busy),
        .status     (status)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: sim time %0t reached, required $finish earlier", $time);
        $fatal(1, "timeout");
    end

    function automatic real fp2r(input logic [15:0] h);
        real v;
        if (h[14:10] == 5'd0) return 0.0;
        v = 1.0 + real'(h[9:0]) / 1024.0;
        for (int e = 15; e < int'(h[14:10]); e++) v = v * 2.0;
        for (int e = 15; e > int'(h[14:10]); e--) v = v / 2.0;
        return v;
    endfunction

    // exact positive reals (multiples of 1/4, < 2048/4) to FP16
    function automatic logic [15:0] r2fp(input real v);
        real m;
        int  e;
        if (v == 0.0) return 16'h0000;
        m = v;
        e = 15;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        return {1'b0, 5'(e), 10'($rtoi((m - 1.0) * 1024.0))};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [15:0] v);
        foreach (lane[i]) lane[i] = v;
    endtask

    task automatic beat(input logic last);
        chk("in_ready_at_beat", in_ready, 1);
        valid_in = 1'b1;
        last_in  = last;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic finish_vec(input string tag, input logic [15:0] exp_sum, input int exp_cnt, input int exp_lat);
        int   lat;
        logic rdy;
        lat = 0;
        rdy = 1'b0;
        while (!outp_valid && lat < 20) begin
            rdy = rdy | in_ready;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_valid"}, outp_valid, 1);
        chk({tag, "_sum"}, outp, exp_sum);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_ready_low_in_drain"}, rdy, 0);
        chk({tag, "_beat_count"}, beat_count, exp_cnt);
        @(posedge clk);
        #1;
        chk({tag, "_pulse_one_cycle"}, outp_valid, 0);
        chk({tag, "_idle"}, busy, 0);
        idle(4);
    endtask

    initial begin
        int   pulses;
        int   nb;
        real  ref_sum;
        set_all(16'h0000);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rst_outp", outp, 0);
        chk("rst_outp_valid", outp_valid, 0);
        chk("rst_beat_count", beat_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_status", status, 0);

        // single beat of 1.0 lanes
        set_all(16'h3C00);
        beat(1'b1);
        chk("single_busy", busy, 1);
        finish_vec("single", 16'h4800, 1, 4);
        chk("single_status", status, 0);

        // two beats of 1.0 lanes
        beat(1'b0);
        beat(1'b1);
        chk("two_ready_low", in_ready, 0);
        finish_vec("two", 16'h4C00, 2, 4);

        // three beats with input gaps and a stray last_in
        lane = '{16'h3C00, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        beat(1'b0);
        last_in = 1'b1;
        idle(2);
        last_in = 1'b0;
        beat(1'b0);
        idle(3);
        chk("gap_still_accum", busy, 1);
        beat(1'b1);
        finish_vec("gaps", 16'h4880, 3, 4);

        // beats offered while draining are ignored
        set_all(16'h3C00);
        beat(1'b1);
        set_all(16'h4000);
        valid_in = 1'b1;
        last_in  = 1'b1;
        repeat (3) begin
            chk("drain_ready_low", in_ready, 0);
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
        finish_vec("drain", 16'h4800, 1, 1);
        beat(1'b0);
        beat(1'b1);
        finish_vec("after_drain", 16'h5000, 2, 4);

        // reset in the middle of a vector
        set_all(16'h3C00);
        beat(1'b0);
        beat(1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("midrst_outp", outp, 0);
        chk("midrst_beat_count", beat_count, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            pulses += int'(outp_valid);
        end
        chk("midrst_no_pulse", pulses, 0);
        beat(1'b1);
        finish_vec("post_rst", 16'h4800, 1, 4);

`ifdef SUM_STATUS_EN
        lane = '{16'h7C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
        beat(1'b1);
        finish_vec("inf", 16'h7C00, 1, 4);
        chk("inf_status_bit", status[1], 1);
        set_all(16'h3C00);
        beat(1'b1);
        finish_vec("clean", 16'h4800, 1, 4);
        chk("clean_status", status, 0);
`endif

        // random vectors against an exact real-valued sum
        for (int v = 0; v < 8; v++) begin
            nb = int'($urandom_range(1, 4));
            ref_sum = 0.0;
            for (int b = 0; b < nb; b++) begin
                foreach (lane[i]) begin
                    lane[i] = tbl[$urandom_range(0, 5)];
                    ref_sum += fp2r(lane[i]);
                end
                beat(b == nb - 1);
                if (b != nb - 1) idle(int'($urandom_range(0, 2)));
            end
            finish_vec("rand", r2fp(ref_sum), nb, 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
